// File: rtl/rob_multiport_pkg.sv
// Shared parameters for the multi-port reorder buffer.
// Holds the default geometry (depth, ID width, CDB/commit port counts) and the
// field widths of an entry, so the top and the CDB matcher agree on defaults.
package rob_multiport_pkg;

  localparam int ROB_DEPTH    = 16;  // entries, power of two
  localparam int ROB_ID_W     = 4;   // log2(ROB_DEPTH)
  localparam int ROB_NUM_CDB  = 2;   // writeback ports
  localparam int ROB_COMMIT_W = 2;   // max retirements per cycle
  localparam int ROB_DATA_W   = 32;  // value / address / pc width
  localparam int ROB_OP_W     = 8;   // op field width
  localparam int ROB_RD_W     = 5;   // destination register width

endpackage

// File: rtl/rob_cdb_match.sv
// Priority match of one ROB ID against all CDB ports.
// Ports:
//   cdb_valid_i   per-port valid
//   cdb_rob_id_i  per-port ROB ID, port k at [k*ID_W +: ID_W]
//   cdb_pay_i     per-port payload, port k at [k*PAY_W +: PAY_W]
//   match_id_i    ID to look for
//   hit_o         some valid port carries match_id_i
//   pay_o         payload of the highest-indexed matching port (0 if no hit)
module rob_cdb_match
  import rob_multiport_pkg::*;
#(
  parameter int NUM_CDB = ROB_NUM_CDB,
  parameter int ID_W    = ROB_ID_W,
  parameter int PAY_W   = ROB_DATA_W
) (
  input  logic [NUM_CDB-1:0]       cdb_valid_i,
  input  logic [NUM_CDB*ID_W-1:0]  cdb_rob_id_i,
  input  logic [NUM_CDB*PAY_W-1:0] cdb_pay_i,
  input  logic [ID_W-1:0]          match_id_i,
  output logic                     hit_o,
  output logic [PAY_W-1:0]         pay_o
);

  // Ascending scan: a later (higher) port overwrites an earlier match.
  always_comb begin
    hit_o = 1'b0;
    pay_o = '0;
    for (int k = 0; k < NUM_CDB; k++) begin
      if (cdb_valid_i[k] && (cdb_rob_id_i[k*ID_W +: ID_W] == match_id_i)) begin
        hit_o = 1'b1;
        pay_o = cdb_pay_i[k*PAY_W +: PAY_W];
      end
    end
  end

endmodule

// File: rtl/rob_multiport.sv
// Multi-port reorder buffer.
// One in-order allocation per cycle, NUM_CDB result writebacks per cycle with
// zero-cycle bypass to two operand queries, up to COMMIT_W retirements per
// cycle from the head, full flush and partial rollback (squash younger than
// rollback_id).
// Ports (vector buses flattened, slot/port k at [k*W +: W]):
//   clk, rst                 clock; rst is asynchronous, active-low
//   flush                    synchronous full flush (reset effect on next edge)
//   rollback_valid/_id       squash entries strictly younger than rollback_id
//   full, empty              occupancy status
//   alloc_req + alloc_*      allocation request and entry fields
//   alloc_id_o               current tail ID (ID given to an accepted alloc)
//   query{1,2}_id/_ready/_value  operand lookups with CDB bypass
//   cdb_*                    writeback ports
//   commit_valid + commit_*_o    retireable head slots, slot k = head+k
//   commit_cnt               number of entries the consumer retires this cycle
// Handshake: commit_valid is a contiguous prefix of retireable slots; the
// consumer retires min(commit_cnt, valid slots) entries on the clock edge.
// An allocation happens on the edge when alloc_req is high and there is room
// (not full, or full while at least one entry retires in the same cycle).
module rob_multiport
  import rob_multiport_pkg::*;
#(
  parameter int DEPTH    = ROB_DEPTH,
  parameter int ID_W     = ROB_ID_W,
  parameter int NUM_CDB  = ROB_NUM_CDB,
  parameter int COMMIT_W = ROB_COMMIT_W,
  parameter int DATA_W   = ROB_DATA_W,
  parameter int OP_W     = ROB_OP_W,
  parameter int RD_W     = ROB_RD_W,
  localparam int CNT_W   = $clog2(COMMIT_W + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       rollback_valid,
  input  logic [ID_W-1:0]            rollback_id,
  output logic                       full,
  output logic                       empty,
  input  logic                       alloc_req,
  input  logic [OP_W-1:0]            alloc_op,
  input  logic [RD_W-1:0]            alloc_rd,
  input  logic [DATA_W-1:0]          alloc_pc,
  input  logic                       alloc_pred,
  input  logic [DATA_W-1:0]          alloc_pred_target,
  output logic [ID_W-1:0]            alloc_id_o,
  input  logic [ID_W-1:0]            query1_id,
  output logic                       query1_ready,
  output logic [DATA_W-1:0]          query1_value,
  input  logic [ID_W-1:0]            query2_id,
  output logic                       query2_ready,
  output logic [DATA_W-1:0]          query2_value,
  input  logic [NUM_CDB-1:0]         cdb_valid,
  input  logic [NUM_CDB*ID_W-1:0]    cdb_rob_id,
  input  logic [NUM_CDB*DATA_W-1:0]  cdb_value,
  input  logic [NUM_CDB*DATA_W-1:0]  cdb_addr,
  input  logic [NUM_CDB-1:0]         cdb_outcome,
  output logic [COMMIT_W-1:0]        commit_valid,
  output logic [COMMIT_W*ID_W-1:0]   commit_id_o,
  output logic [COMMIT_W*OP_W-1:0]   commit_op_o,
  output logic [COMMIT_W*RD_W-1:0]   commit_rd_o,
  output logic [COMMIT_W*DATA_W-1:0] commit_value_o,
  output logic [COMMIT_W*DATA_W-1:0] commit_pc_o,
  output logic [COMMIT_W*DATA_W-1:0] commit_addr_o,
  output logic [COMMIT_W-1:0]        commit_pred_o,
  output logic [COMMIT_W-1:0]        commit_outcome_o,
  output logic [COMMIT_W*DATA_W-1:0] commit_pred_target_o,
  input  logic [CNT_W-1:0]           commit_cnt
);

  localparam int CW    = ID_W + 1;        // count width, holds 0..DEPTH
  localparam int PAY_W = 2 * DATA_W + 1;  // {outcome, addr, value}

  logic [ID_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DEPTH-1:0]  busy_q, busy_d, ready_q, ready_d;
  logic [DEPTH-1:0]  pred_q, pred_d, outc_q, outc_d;
  logic [OP_W-1:0]   op_q    [DEPTH];
  logic [OP_W-1:0]   op_d    [DEPTH];
  logic [RD_W-1:0]   rd_q    [DEPTH];
  logic [RD_W-1:0]   rd_d    [DEPTH];
  logic [DATA_W-1:0] pc_q    [DEPTH];
  logic [DATA_W-1:0] pc_d    [DEPTH];
  logic [DATA_W-1:0] ptgt_q  [DEPTH];
  logic [DATA_W-1:0] ptgt_d  [DEPTH];
  logic [DATA_W-1:0] value_q [DEPTH];
  logic [DATA_W-1:0] value_d [DEPTH];
  logic [DATA_W-1:0] addr_q  [DEPTH];
  logic [DATA_W-1:0] addr_d  [DEPTH];

  logic [NUM_CDB*PAY_W-1:0] cdb_pay;
  logic [DEPTH-1:0]         ent_hit;
  logic [PAY_W-1:0]         ent_pay [DEPTH];
  logic                     q1_hit, q2_hit;
  logic [DATA_W-1:0]        q1_val, q2_val;

  logic [CNT_W-1:0] eff_raw, eff;
  logic [ID_W-1:0]  rb_off;
  logic             rb_apply;
  logic             alloc_acc;

  assign full       = (count_q == CW'(DEPTH));
  assign empty      = (count_q == '0);
  assign alloc_id_o = tail_q;

  // ---------------------------------------------------------------- CDB match
  always_comb begin
    cdb_pay = '0;
    for (int k = 0; k < NUM_CDB; k++) begin
      cdb_pay[k*PAY_W +: PAY_W] = {cdb_outcome[k], cdb_addr[k*DATA_W +: DATA_W],
                                   cdb_value[k*DATA_W +: DATA_W]};
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    rob_cdb_match #(.NUM_CDB(NUM_CDB), .ID_W(ID_W), .PAY_W(PAY_W)) u_match (
      .cdb_valid_i  (cdb_valid),
      .cdb_rob_id_i (cdb_rob_id),
      .cdb_pay_i    (cdb_pay),
      .match_id_i   (ID_W'(i)),
      .hit_o        (ent_hit[i]),
      .pay_o        (ent_pay[i])
    );
  end

  rob_cdb_match #(.NUM_CDB(NUM_CDB), .ID_W(ID_W), .PAY_W(DATA_W)) u_q1_match (
    .cdb_valid_i  (cdb_valid),
    .cdb_rob_id_i (cdb_rob_id),
    .cdb_pay_i    (cdb_value),
    .match_id_i   (query1_id),
    .hit_o        (q1_hit),
    .pay_o        (q1_val)
  );

  rob_cdb_match #(.NUM_CDB(NUM_CDB), .ID_W(ID_W), .PAY_W(DATA_W)) u_q2_match (
    .cdb_valid_i  (cdb_valid),
    .cdb_rob_id_i (cdb_rob_id),
    .cdb_pay_i    (cdb_value),
    .match_id_i   (query2_id),
    .hit_o        (q2_hit),
    .pay_o        (q2_val)
  );

  // A bypassed result only makes the operand ready if the entry is live.
  assign query1_ready = ready_q[query1_id] || (q1_hit && busy_q[query1_id]);
  assign query1_value = q1_hit ? q1_val : value_q[query1_id];
  assign query2_ready = ready_q[query2_id] || (q2_hit && busy_q[query2_id]);
  assign query2_value = q2_hit ? q2_val : value_q[query2_id];

  // ------------------------------------------------------------ commit prefix
  always_comb begin : p_commit
    logic            prefix;
    logic [ID_W-1:0] idx;
    prefix               = 1'b1;
    idx                  = '0;
    eff_raw              = '0;
    commit_valid         = '0;
    commit_id_o          = '0;
    commit_op_o          = '0;
    commit_rd_o          = '0;
    commit_value_o       = '0;
    commit_pc_o          = '0;
    commit_addr_o        = '0;
    commit_pred_o        = '0;
    commit_outcome_o     = '0;
    commit_pred_target_o = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      idx    = head_q + ID_W'(k);
      prefix = prefix && (k < int'(count_q)) && ready_q[idx];
      commit_valid[k]                         = prefix;
      commit_id_o[k*ID_W +: ID_W]             = idx;
      commit_op_o[k*OP_W +: OP_W]             = op_q[idx];
      commit_rd_o[k*RD_W +: RD_W]             = rd_q[idx];
      commit_value_o[k*DATA_W +: DATA_W]      = value_q[idx];
      commit_pc_o[k*DATA_W +: DATA_W]         = pc_q[idx];
      commit_addr_o[k*DATA_W +: DATA_W]       = addr_q[idx];
      commit_pred_o[k]                        = pred_q[idx];
      commit_outcome_o[k]                     = outc_q[idx];
      commit_pred_target_o[k*DATA_W +: DATA_W] = ptgt_q[idx];
      if (prefix && (k < int'(commit_cnt))) begin
        eff_raw = eff_raw + CNT_W'(1);
      end
    end
  end

  // rb_off is the rollback target's age position (0 = head). During a rollback
  // nothing younger than the target may retire, so retirement is capped there.
  assign rb_off   = rollback_id - head_q;
  assign rb_apply = rollback_valid && busy_q[rollback_id] && !flush;

  always_comb begin
    eff = eff_raw;
    if (rb_apply && (int'(eff_raw) > int'(rb_off) + 1)) begin
      eff = CNT_W'(int'(rb_off) + 1);
    end
  end

  // A retirement in the same cycle frees a slot, so a full ROB can still accept.
  assign alloc_acc = alloc_req && !flush && !rollback_valid && (!full || (eff != '0));

  // --------------------------------------------------------------- next state
  always_comb begin : p_next
    logic [ID_W-1:0] off;
    logic            squash;
    off     = '0;
    squash  = 1'b0;
    busy_d  = busy_q;
    ready_d = ready_q;
    pred_d  = pred_q;
    outc_d  = outc_q;
    op_d    = op_q;
    rd_d    = rd_q;
    pc_d    = pc_q;
    ptgt_d  = ptgt_q;
    value_d = value_q;
    addr_d  = addr_q;

    for (int i = 0; i < DEPTH; i++) begin
      off    = ID_W'(i) - head_q;
      squash = rb_apply && busy_q[i] && (off > rb_off);
      if (ent_hit[i] && busy_q[i] && !squash) begin
        ready_d[i] = 1'b1;
        {outc_d[i], addr_d[i], value_d[i]} = ent_pay[i];
      end
      // Squashed and retiring entries both become free.
      if (squash || (int'(off) < int'(eff))) begin
        busy_d[i]  = 1'b0;
        ready_d[i] = 1'b0;
      end
    end

    // Last so that a full ROB can reuse the slot retired in this same cycle.
    if (alloc_acc) begin
      busy_d[tail_q]  = 1'b1;
      ready_d[tail_q] = 1'b0;
      op_d[tail_q]    = alloc_op;
      rd_d[tail_q]    = alloc_rd;
      pc_d[tail_q]    = alloc_pc;
      pred_d[tail_q]  = alloc_pred;
      ptgt_d[tail_q]  = alloc_pred_target;
    end

    head_d = head_q + ID_W'(eff);
    if (rb_apply) begin
      tail_d  = rollback_id + ID_W'(1);
      count_d = CW'(rb_off) + CW'(1) - CW'(eff);
    end else begin
      tail_d  = tail_q + ID_W'(alloc_acc);
      count_d = count_q + CW'(alloc_acc) - CW'(eff);
    end
  end

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      busy_q  <= '0;
      ready_q <= '0;
      pred_q  <= '0;
      outc_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]    <= '0;
        rd_q[i]    <= '0;
        pc_q[i]    <= '0;
        ptgt_q[i]  <= '0;
        value_q[i] <= '0;
        addr_q[i]  <= '0;
      end
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      busy_q  <= '0;
      ready_q <= '0;
      pred_q  <= '0;
      outc_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]    <= '0;
        rd_q[i]    <= '0;
        pc_q[i]    <= '0;
        ptgt_q[i]  <= '0;
        value_q[i] <= '0;
        addr_q[i]  <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      pred_q  <= pred_d;
      outc_q  <= outc_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      pc_q    <= pc_d;
      ptgt_q  <= ptgt_d;
      value_q <= value_d;
      addr_q  <= addr_d;
    end
  end

endmodule

// File: tb/tb_rob_multiport.sv
// Self-checking bench for rob_multiport: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against an
// in-order queue model of the ROB.
module tb_rob_multiport;

  localparam int D  = 16;
  localparam int NC = 2;
  localparam int CWD = 2;

  // ------------------------------------------------------ clock / reset block
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        flush, rollback_valid, alloc_req, alloc_pred;
  logic [3:0]  rollback_id, query1_id, query2_id;
  logic [7:0]  alloc_op;
  logic [4:0]  alloc_rd;
  logic [31:0] alloc_pc, alloc_pred_target;
  logic [1:0]  cdb_valid, cdb_outcome, commit_cnt;
  logic [7:0]  cdb_rob_id;
  logic [63:0] cdb_value, cdb_addr;

  logic        full, empty, query1_ready, query2_ready;
  logic [3:0]  alloc_id_o;
  logic [31:0] query1_value, query2_value;
  logic [1:0]  commit_valid, commit_pred_o, commit_outcome_o;
  logic [7:0]  commit_id_o;
  logic [15:0] commit_op_o;
  logic [9:0]  commit_rd_o;
  logic [63:0] commit_value_o, commit_pc_o, commit_addr_o, commit_pred_target_o;

  rob_multiport dut (
    .clk(clk), .rst(rst), .flush(flush),
    .rollback_valid(rollback_valid), .rollback_id(rollback_id),
    .full(full), .empty(empty),
    .alloc_req(alloc_req), .alloc_op(alloc_op), .alloc_rd(alloc_rd), .alloc_pc(alloc_pc),
    .alloc_pred(alloc_pred), .alloc_pred_target(alloc_pred_target), .alloc_id_o(alloc_id_o),
    .query1_id(query1_id), .query1_ready(query1_ready), .query1_value(query1_value),
    .query2_id(query2_id), .query2_ready(query2_ready), .query2_value(query2_value),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value),
    .cdb_addr(cdb_addr), .cdb_outcome(cdb_outcome),
    .commit_valid(commit_valid), .commit_id_o(commit_id_o), .commit_op_o(commit_op_o),
    .commit_rd_o(commit_rd_o), .commit_value_o(commit_value_o), .commit_pc_o(commit_pc_o),
    .commit_addr_o(commit_addr_o), .commit_pred_o(commit_pred_o),
    .commit_outcome_o(commit_outcome_o), .commit_pred_target_o(commit_pred_target_o),
    .commit_cnt(commit_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ------------------------------------------------------------ model state
  // Live entries are the IDs in order_q, oldest first; head is tracked so the
  // tail ID is known even when the ROB is empty.
  int          order_q[$];
  int          m_head;
  bit          m_ready [D];
  logic [31:0] m_value [D];
  logic [31:0] m_addr  [D];
  bit          m_outc  [D];
  logic [7:0]  m_op    [D];
  logic [4:0]  m_rd    [D];
  logic [31:0] m_pc    [D];
  bit          m_pred  [D];
  logic [31:0] m_ptgt  [D];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    order_q.delete();
    m_head = 0;
    for (int i = 0; i < D; i++) begin
      m_ready[i] = 0; m_value[i] = '0; m_addr[i] = '0; m_outc[i] = 0;
      m_op[i] = '0; m_rd[i] = '0; m_pc[i] = '0; m_pred[i] = 0; m_ptgt[i] = '0;
    end
  endtask

  function automatic int pos_of(input int id);
    for (int i = 0; i < order_q.size(); i++) if (order_q[i] == id) return i;
    return -1;
  endfunction

  function automatic logic [1:0] exp_cv();
    logic [1:0] cv = '0;
    bit pre = 1;
    for (int k = 0; k < CWD; k++) begin
      if (k < order_q.size()) pre = pre && m_ready[order_q[k]];
      else                    pre = 0;
      cv[k] = pre;
    end
    return cv;
  endfunction

  // Query expectation: stored ready, or a live entry hit by a CDB this cycle.
  task automatic chk_query(input string name, input logic [3:0] id,
                           input logic rdy, input logic [31:0] val);
    bit hit = 0;
    logic [31:0] hv = '0;
    bit er;
    for (int k = 0; k < NC; k++)
      if (cdb_valid[k] && cdb_rob_id[k*4 +: 4] == id) begin hit = 1; hv = cdb_value[k*32 +: 32]; end
    er = m_ready[id] || (hit && pos_of(int'(id)) >= 0);
    chk({name, "_ready"}, rdy, er);
    if (er) chk({name, "_value"}, val, hit ? hv : m_value[id]);
  endtask

  // ------------------------------------------------------ compare process
  task automatic check_cycle();
    int sz = order_q.size();
    logic [1:0] cv = exp_cv();
    chk("full", full, sz == D);
    chk("empty", empty, sz == 0);
    chk("alloc_id", alloc_id_o, (m_head + sz) % D);
    chk("commit_valid", commit_valid, cv);
    for (int k = 0; k < CWD; k++) begin
      if (cv[k]) begin
        int id = order_q[k];
        chk("commit_id", commit_id_o[k*4 +: 4], id);
        chk("commit_op", commit_op_o[k*8 +: 8], m_op[id]);
        chk("commit_rd", commit_rd_o[k*5 +: 5], m_rd[id]);
        chk("commit_value", commit_value_o[k*32 +: 32], m_value[id]);
        chk("commit_pc", commit_pc_o[k*32 +: 32], m_pc[id]);
        chk("commit_addr", commit_addr_o[k*32 +: 32], m_addr[id]);
        chk("commit_pred", commit_pred_o[k], m_pred[id]);
        chk("commit_outcome", commit_outcome_o[k], m_outc[id]);
        chk("commit_ptgt", commit_pred_target_o[k*32 +: 32], m_ptgt[id]);
      end
    end
    chk_query("q1", query1_id, query1_ready, query1_value);
    chk_query("q2", query2_id, query2_ready, query2_value);
  endtask

  // Apply the current inputs to the model as of the coming clock edge.
  task automatic model_update();
    int sz = order_q.size();
    int eff = 0, p = -1, aid;
    bit rb, do_alloc;
    logic [1:0] cv = exp_cv();
    if (flush) begin model_reset(); return; end
    for (int k = 0; k < CWD; k++) if (cv[k] && k < int'(commit_cnt)) eff++;
    p  = pos_of(int'(rollback_id));
    rb = rollback_valid && (p >= 0);
    if (rb && eff > p + 1) eff = p + 1;
    do_alloc = alloc_req && !rollback_valid && (sz < D || eff > 0);
    aid = (m_head + sz) % D;
    for (int k = 0; k < NC; k++) begin
      if (cdb_valid[k]) begin
        int id = int'(cdb_rob_id[k*4 +: 4]);
        int pk = pos_of(id);
        if (pk >= 0 && !(rb && pk > p)) begin
          m_ready[id] = 1;
          m_value[id] = cdb_value[k*32 +: 32];
          m_addr[id]  = cdb_addr[k*32 +: 32];
          m_outc[id]  = cdb_outcome[k];
        end
      end
    end
    if (rb) while (order_q.size() > p + 1) m_ready[order_q.pop_back()] = 0;
    repeat (eff) begin
      m_ready[order_q.pop_front()] = 0;
      m_head = (m_head + 1) % D;
    end
    if (do_alloc) begin
      order_q.push_back(aid);
      m_ready[aid] = 0; m_op[aid] = alloc_op; m_rd[aid] = alloc_rd; m_pc[aid] = alloc_pc;
      m_pred[aid] = alloc_pred; m_ptgt[aid] = alloc_pred_target;
    end
  endtask

  // ------------------------------------------------------------ driver tasks
  task automatic idle();
    flush = 0; rollback_valid = 0; rollback_id = '0; alloc_req = 0;
    alloc_op = $urandom; alloc_rd = $urandom; alloc_pc = $urandom;
    alloc_pred = $urandom; alloc_pred_target = $urandom;
    query1_id = '0; query2_id = '0;
    cdb_valid = '0; cdb_rob_id = '0; cdb_value = '0; cdb_addr = '0; cdb_outcome = '0;
    commit_cnt = '0;
  endtask

  task automatic set_cdb(input int k, input int id, input logic [31:0] val);
    cdb_valid[k] = 1'b1;
    cdb_rob_id[k*4 +: 4] = 4'(id);
    cdb_value[k*32 +: 32] = val;
    cdb_addr[k*32 +: 32] = $urandom;
    cdb_outcome[k] = 1'($urandom);
  endtask

  // Inputs are driven just after a falling edge; check, update model, advance.
  task automatic step();
    #1;
    check_cycle();
    model_update();
    @(negedge clk);
  endtask

  function automatic int pick_id();
    if (order_q.size() > 0 && $urandom_range(0, 3) != 0)
      return order_q[$urandom_range(0, order_q.size() - 1)];
    return $urandom_range(0, D - 1);
  endfunction

  task automatic drive_random();
    idle();
    alloc_req = ($urandom_range(0, 9) < 6);
    for (int k = 0; k < NC; k++) if ($urandom_range(0, 1)) set_cdb(k, pick_id(), $urandom);
    commit_cnt = 2'($urandom_range(0, 3));
    if ($urandom_range(0, 19) == 0) begin rollback_valid = 1; rollback_id = 4'(pick_id()); end
    if ($urandom_range(0, 99) == 0) flush = 1;
    query1_id = (cdb_valid[0] && $urandom_range(0, 1)) ? cdb_rob_id[3:0] : 4'(pick_id());
    query2_id = 4'(pick_id());
  endtask

  task automatic do_reset();
    rst = 0;
    #1;
    model_reset();
    @(negedge clk);
    rst = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1;
    #1;
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_cv", commit_valid, 0);
    chk("rst_alloc_id", alloc_id_o, 0);

    // 1: fill to 16, 17th dropped
    for (int i = 0; i < D; i++) begin
      idle(); alloc_req = 1;
      #1 chk("t1_alloc_id", alloc_id_o, i);
      step();
    end
    idle(); alloc_req = 1;
    #1 chk("t1_full", full, 1);
    chk("t1_tail_wrap", alloc_id_o, 0);
    step();
    idle();
    #1 chk("t1_still_full", full, 1);

    // 2: ids 0,1,3 ready, retire two, then blocked on id2
    set_cdb(0, 0, 32'h100); set_cdb(1, 1, 32'h101);
    step();
    idle(); set_cdb(0, 3, 32'h103);
    step();
    idle(); commit_cnt = 2;
    #1 chk("t2_cv", commit_valid, 2'b11);
    chk("t2_val1", commit_value_o[63:32], 32'h101);
    step();
    idle(); commit_cnt = 2;
    #1 chk("t2_cv_blocked", commit_valid, 2'b00);
    chk("t2_head", commit_id_o[3:0], 2);
    chk("t2_not_full", full, 0);
    step();

    // 3: two ports hit id5, higher port wins, bypass to query
    idle(); set_cdb(0, 5, 32'hAAAA); set_cdb(1, 5, 32'hBBBB); query1_id = 5;
    #1 chk("t3_byp_ready", query1_ready, 1);
    chk("t3_byp_value", query1_value, 32'hBBBB);
    step();
    idle(); query1_id = 5;
    #1 chk("t3_stored_value", query1_value, 32'hBBBB);
    step();

    // 4: head=14, tail=4, rollback to id 0
    idle(); do_reset();
    for (int i = 0; i < 14; i++) begin idle(); alloc_req = 1; step(); end
    for (int j = 0; j < 8; j++) begin
      idle(); commit_cnt = 2;
      if (j < 7) begin set_cdb(0, 2*j, $urandom); set_cdb(1, 2*j+1, $urandom); end
      step();
    end
    for (int i = 0; i < 6; i++) begin idle(); alloc_req = 1; step(); end
    idle();
    #1 chk("t4_tail", alloc_id_o, 4);
    chk("t4_head", commit_id_o[3:0], 14);
    rollback_valid = 1; rollback_id = 0;
    step();
    idle(); query1_id = 2; set_cdb(0, 2, 32'h222);
    #1 chk("t4_new_tail", alloc_id_o, 1);
    chk("t4_late_cdb", query1_ready, 0);
    step();
    for (int i = 0; i < 13; i++) begin
      idle(); alloc_req = 1;
      if (i == 12) #1 chk("t4_count3_not_full", full, 0);
      step();
    end
    idle();
    #1 chk("t4_count3_full", full, 1);

    // 5: alloc + commit while full
    set_cdb(0, 14, 32'h1414);
    step();
    idle(); alloc_req = 1; commit_cnt = 1;
    #1 chk("t5_cv0", commit_valid[0], 1);
    chk("t5_tail", alloc_id_o, 14);
    step();
    idle();
    #1 chk("t5_full", full, 1);
    chk("t5_tail_adv", alloc_id_o, 15);
    chk("t5_head_adv", commit_id_o[3:0], 15);

    // 6: async reset mid-burst, then flush
    for (int i = 0; i < 5; i++) begin drive_random(); flush = 0; step(); end
    idle();
    @(posedge clk);
    #2 rst = 0;
    #1 chk("t6_arst_full", full, 0);
    chk("t6_arst_empty", empty, 1);
    chk("t6_arst_cv", commit_valid, 0);
    chk("t6_arst_id", alloc_id_o, 0);
    model_reset();
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < 3; i++) begin idle(); alloc_req = 1; step(); end
    idle(); flush = 1; alloc_req = 1;
    step();
    idle();
    #1 chk("t6_flush_empty", empty, 1);
    chk("t6_flush_id", alloc_id_o, 0);
    chk("t6_flush_cv", commit_valid, 0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      drive_random();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
